cp0_interrupt_unit: RTL and testbench

Coprocessor-0 interrupt receiver for the single-cycle MIPS datapath: the consuming end of the memory-mapped peripheral interrupt lines, the timer's `TimerInterrupt` included. It samples up to eight level-sensitive request lines, masks them against a software-writable Status register, and raises `TakenInterrupt` to redirect fetch. It saves the return PC in EPC and restores control on `eret`. Software clears each request at its source; the timer, for example, is acknowledged by a store to its acknowledge address.

---
 rtl/cp0_interrupt_unit.sv | 116 +++++++++++
 tb/tb_cp0_interrupt_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_interrupt_unit.sv
// cp0_interrupt_unit: Coprocessor-0 interrupt receiver for the single-cycle MIPS datapath.
// The unit samples eight level-sensitive request lines into Cause.IP, where irq[7] is
// the timer. It masks them with Status.IM/IE/EXL and raises TakenInterrupt to redirect
// fetch to handler_pc.
// The PC of the squashed instruction goes to EPC, and ERET returns control.
// Optional build macro: CP0_IRQ_ID_EN. When it is defined, Cause[4:2] latches the
// highest-numbered pending unmasked line at each take.
module cp0_interrupt_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq,
  input  logic [31:0] pc,
  input  logic [4:0]  regnum,
  input  logic [31:0] wr_data,
  input  logic        MTC0,
  input  logic        ERET,
  input  logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] EPC,
  output logic [31:0] handler_pc,
  output logic        TakenInterrupt
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  // Status fields
  logic [7:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic [7:0]  ip;
  logic [2:0]  irq_id;
  // Saved return PC
  logic [31:0] epc;

  logic        take;
  logic [7:0]  pending;

  // Status only keeps IM/EXL/IE; the remaining write-data bits have no home.
  logic        unused_wr_bits;
  assign unused_wr_bits = ^{wr_data[31:16], wr_data[7:2]};

  assign pending        = ip & im;
  assign take           = (|pending) & ie & ~exl & ~stall;
  assign TakenInterrupt = take;
  assign handler_pc     = HANDLER_ADDR;
  assign EPC            = epc;

  // Register file update: a take beats any MTC0/ERET in the same cycle, and ERET beats MTC0 on EXL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      im  <= 8'h00;
      exl <= 1'b0;
      ie  <= 1'b0;
      ip  <= 8'h00;
      epc <= 32'h0;
    end else begin
      ip <= irq;
      if (take) begin
        epc <= pc;
        exl <= 1'b1;
      end else begin
        if (MTC0 && (regnum == REG_STATUS)) begin
          im  <= wr_data[15:8];
          exl <= wr_data[1];
          ie  <= wr_data[0];
        end
        if (MTC0 && (regnum == REG_EPC)) begin
          epc <= wr_data;
        end
        if (ERET) begin
          exl <= 1'b0;
        end
      end
    end
  end

`ifdef CP0_IRQ_ID_EN
  logic [2:0] top_line;

  // Priority encoder: the highest-numbered pending unmasked line wins.
  always_comb begin
    top_line = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) top_line = i[2:0];
    end
  end

  // IRQ ID capture: latched only at a take and held until the next one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_id <= 3'd0;
    end else if (take) begin
      irq_id <= top_line;
    end
  end
`else
  assign irq_id = 3'd0;
`endif

  // mfc0 read mux, combinational on regnum with no write-through bypass.
  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      REG_STATUS: rd_data = {16'h0, im, 6'b0, exl, ie};
      REG_CAUSE:  rd_data = {16'h0, ip, 3'b0, irq_id, 2'b00};
      REG_EPC:    rd_data = epc;
      default:    rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// tb_cp0_interrupt_unit: self-checking bench for cp0_interrupt_unit.
// A word-level model of Status/Cause/EPC is compared against the DUT on every falling
// edge. Directed literal checks pin the model, and randomized traffic follows them.
// Build with +define+CP0_IRQ_ID_EN to exercise the IRQ ID field.
module tb_cp0_interrupt_unit;

  localparam logic [31:0] HANDLER = 32'h8000_0180;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic [31:0] pc;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic        MTC0;
  logic        ERET;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] EPC;
  logic [31:0] handler_pc;
  logic        TakenInterrupt;

  always #5 clock = ~clock;

  cp0_interrupt_unit #(.HANDLER_ADDR(HANDLER)) dut (
    .clock(clock), .reset(reset), .irq(irq), .pc(pc), .regnum(regnum),
    .wr_data(wr_data), .MTC0(MTC0), .ERET(ERET), .stall(stall),
    .rd_data(rd_data), .EPC(EPC), .handler_pc(handler_pc),
    .TakenInterrupt(TakenInterrupt)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit run_check  = 1'b0;

  // ---------------- behavioural model ----------------
  // Architectural words as software sees them.
  logic [31:0] m_status;
  logic [7:0]  m_ip;
  logic [2:0]  m_id;
  logic [31:0] m_epc;
  logic [31:0] exp_q[$];   // expected EPC after each modelled take

  function automatic logic [2:0] highest_line(input logic [7:0] p);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (p[i]) r = i[2:0];
    return r;
  endfunction

  function automatic logic m_take_now();
    return ((m_ip & m_status[15:8]) != 8'h00) && m_status[0] && !m_status[1] && !stall;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd12:   return m_status;
      5'd13:   return {16'h0, m_ip, 3'b000, m_id, 2'b00};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_status = 32'h0;
      m_ip     = 8'h0;
      m_id     = 3'd0;
      m_epc    = 32'h0;
      exp_q.delete();
    end else begin
      if (m_take_now()) begin
`ifdef CP0_IRQ_ID_EN
        m_id = highest_line(m_ip & m_status[15:8]);
`endif
        m_epc    = pc;
        m_status = m_status | 32'h2;
        exp_q.push_back(pc);
      end else begin
        if (MTC0 && regnum == 5'd12) m_status = wr_data & 32'h0000_FF03;
        if (MTC0 && regnum == 5'd14) m_epc = wr_data;
        if (ERET) m_status = m_status & ~32'h2;
      end
      m_ip = irq;
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (run_check) begin
      check("taken", {31'h0, TakenInterrupt}, {31'h0, m_take_now()});
      check("rd_data", rd_data, m_read(regnum));
      check("epc", EPC, m_epc);
      check("handler_pc", handler_pc, HANDLER);
      if (exp_q.size() > 0) begin
        check("epc_after_take", EPC, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    MTC0 = 1'b0; ERET = 1'b0; stall = 1'b0; wr_data = 32'h0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  id_exp;
  logic [4:0]  reg_tab [4];

  initial begin
    reg_tab[0] = 5'd12; reg_tab[1] = 5'd13; reg_tab[2] = 5'd14; reg_tab[3] = 5'd0;
    reset = 1'b1; irq = 8'h00; pc = 32'h0; regnum = 5'd12;
    idle_inputs();
    run_check = 1'b1;

    // Reset state
    at_neg();
    check("reset_status", rd_data, 32'h0);
    check("reset_taken", {31'h0, TakenInterrupt}, 32'h0);
    regnum = 5'd13;
    #1;
    check("reset_cause", rd_data, 32'h0);
    tick();
    reset = 1'b0;

    // Masked request: no take, Cause.IP visible one cycle later
    irq = 8'h80; regnum = 5'd13;
    at_neg();
    check("cause_before_edge", rd_data, 32'h0);
    tick();
    at_neg();
    check("cause_ip7", rd_data, 32'h0000_8000);
    check("no_take_masked", {31'h0, TakenInterrupt}, 32'h0);

    // Enable IM7/IE, take with pc 0x00400010
    tick();
    MTC0 = 1'b1; regnum = 5'd12; wr_data = 32'h0000_8001; pc = 32'h0040_0010;
    tick();
    MTC0 = 1'b0;
    at_neg();
    check("take_basic", {31'h0, TakenInterrupt}, 32'h1);
    tick();
    at_neg();
    check("take_one_cycle", {31'h0, TakenInterrupt}, 32'h0);
    check("epc_basic", EPC, 32'h0040_0010);
    check("status_exl", rd_data, 32'h0000_8003);

    // Stall defers the take for three cycles
    tick();
    ERET = 1'b1;
    tick();
    ERET = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h0040_0100 + 32'(4 * k);
      at_neg();
      check("stall_no_take", {31'h0, TakenInterrupt}, 32'h0);
      tick();
    end
    stall = 1'b0; pc = 32'h0040_0200;
    at_neg();
    check("take_after_stall", {31'h0, TakenInterrupt}, 32'h1);
    tick();
    at_neg();
    check("epc_after_stall", EPC, 32'h0040_0200);

    // Take discards a simultaneous MTC0
    tick();
    ERET = 1'b1;
    tick();
    ERET = 1'b0; MTC0 = 1'b1; regnum = 5'd12; wr_data = 32'h0; pc = 32'h0040_0300;
    at_neg();
    check("take_with_mtc0", {31'h0, TakenInterrupt}, 32'h1);
    tick();
    MTC0 = 1'b0;
    at_neg();
    check("mtc0_discarded", rd_data, 32'h0000_8003);
    check("epc_mtc0_cycle", EPC, 32'h0040_0300);

    // ERET with irq[7] still high: retaken next cycle
    tick();
    ERET = 1'b1; pc = 32'h0040_0400;
    tick();
    ERET = 1'b0; pc = 32'h0040_0404;
    at_neg();
    check("retake_after_eret", {31'h0, TakenInterrupt}, 32'h1);
    tick();
    at_neg();
    check("epc_retake", EPC, 32'h0040_0404);

    // IRQ ID with IM=FF, irq=24
    tick();
    irq = 8'h24; ERET = 1'b1;
    tick();
    ERET = 1'b0; MTC0 = 1'b1; regnum = 5'd12; wr_data = 32'h0000_FF01;
    at_neg();
    check("no_take_im80", {31'h0, TakenInterrupt}, 32'h0);
    tick();
    MTC0 = 1'b0; pc = 32'h0040_0500;
    at_neg();
    check("take_id", {31'h0, TakenInterrupt}, 32'h1);
    tick();
    regnum = 5'd13;
`ifdef CP0_IRQ_ID_EN
    id_exp = 3'd5;
`else
    id_exp = 3'd0;
`endif
    at_neg();
    check("cause_irq_id", rd_data, {16'h0, 8'h24, 3'b000, id_exp, 2'b00});

    // Reset asserted while a take is pending drops TakenInterrupt in the same cycle
    tick();
    ERET = 1'b1;
    tick();
    ERET = 1'b0; regnum = 5'd12;
    #1;
    check("pending_before_reset", {31'h0, TakenInterrupt}, 32'h1);
    reset = 1'b1;
    #1;
    check("reset_drops_take", {31'h0, TakenInterrupt}, 32'h0);
    check("reset_clears_status", rd_data, 32'h0);
    tick();
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      regnum  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : reg_tab[$urandom_range(0, 3)];
      pc      = $urandom;
      wr_data = $urandom;
      if ($urandom_range(0, 1) == 0) wr_data[1:0] = 2'b01;
      MTC0    = ($urandom_range(0, 7) == 0);
      ERET    = ($urandom_range(0, 5) == 0);
      stall   = ($urandom_range(0, 3) == 0);
    end
    tick();
    idle_inputs();
    at_neg();
    run_check = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
